// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - digit-serial adder driving one 2-bit ripple slice per clock
//
// dsa_slice2: 2-bit ripple-carry adder slice.
//   a, b  : 2-bit addends
//   cin   : carry in
//   s     : 2-bit sum
//   cout  : carry out
//
// digit_serial_adder: WIDTH-bit adder, one 2-bit digit per clock, LSB first.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request pulse; A, B, Cin sampled on the same edge (ignored while busy)
//   A, B, Cin  : operands and carry-in
//   busy       : high while digits are being processed
//   done       : one-cycle pulse when S/Cout are updated
//   S, Cout    : registered result, held until the next completed add

module dsa_slice2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic c1;

  always_comb begin
    s[0] = a[0] ^ b[0] ^ cin;
    c1   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
    s[1] = a[1] ^ b[1] ^ c1;
    cout = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
  end

endmodule

module digit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int ND = WIDTH / 2;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [1:0]       slice_s;
  logic             slice_cout;
  logic [WIDTH-1:0] psum_shift;
  logic             last_digit;

  dsa_slice2 u_slice (
    .a    (opa_q[1:0]),
    .b    (opb_q[1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Sum digits enter at the MSB end so that after ND shifts digit 0 sits at bit 0.
  if (WIDTH == 2) begin : g_psum_narrow
    assign psum_shift = slice_s;
  end else begin : g_psum_wide
    assign psum_shift = {slice_s, psum_q[WIDTH-1:2]};
  end

  assign last_digit = (cnt_q == '0);

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      psum_q  <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      psum_q  <= psum_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; start is only honoured outside RUN
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    psum_d  = psum_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (state_q == RUN) begin
      opa_d   = opa_q >> 2;
      opb_d   = opb_q >> 2;
      psum_d  = psum_shift;
      carry_d = slice_cout;
      cnt_d   = cnt_q - CW'(1);
      if (last_digit) begin
        s_d    = psum_shift;
        cout_d = slice_cout;
      end
    end else if (start) begin
      opa_d   = A;
      opb_d   = B;
      carry_d = Cin;
      cnt_d   = CW'(ND - 1);
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    S    = s_q;
    Cout = cout_q;
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - directed self-checking bench for digit_serial_adder (WIDTH=8)

module tb_digit_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] A, B;
  logic       Cin;
  logic       busy, done;
  logic [7:0] S;
  logic       Cout;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] prev_s;
  logic       prev_c;

  digit_serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge; pulses start across exactly one rising edge.
  task automatic go(input logic [7:0] a, input logic [7:0] b, input logic c);
    A = a; B = b; Cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walks the 4 RUN cycles then checks the done cycle. poke>=0 drives a
  // stray start (0x01+0x01) in that RUN cycle, which must be ignored.
  task automatic follow(input string tag, input logic [7:0] exp_s, input logic exp_c, input int poke);
    for (int i = 0; i < 4; i++) begin
      chk({tag, " busy"}, busy, 1'b1);
      chk({tag, " no_done"}, done, 1'b0);
      chk({tag, " S_hold"}, S, prev_s);
      chk({tag, " Cout_hold"}, Cout, prev_c);
      if (i == poke) begin
        A = 8'h01; B = 8'h01; Cin = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " busy_off"}, busy, 1'b0);
    chk({tag, " S"}, S, exp_s);
    chk({tag, " Cout"}, Cout, exp_c);
    prev_s = exp_s;
    prev_c = exp_c;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    prev_s = 8'h00; prev_c = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst S", S, 8'h00);
    chk("rst Cout", Cout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", busy, 1'b0);

    go(8'h00, 8'h02, 1'b0);
    follow("t00_02", 8'h02, 1'b0, -1);
    @(negedge clk);
    chk("t00_02 done_pulse", done, 1'b0);

    go(8'hFF, 8'h01, 1'b0);
    follow("tFF_01", 8'h00, 1'b1, -1);
    @(negedge clk);

    go(8'hAA, 8'h55, 1'b1);
    follow("tAA_55", 8'h00, 1'b1, -1);
    @(negedge clk);

    go(8'h96, 8'h3C, 1'b0);
    follow("t96_3C", 8'hD2, 1'b0, -1);
    @(negedge clk);

    go(8'h96, 8'h3C, 1'b0);
    follow("ignore", 8'hD2, 1'b0, 1);
    @(negedge clk);
    chk("ignore done_once", done, 1'b0);
    chk("ignore idle", busy, 1'b0);
    @(negedge clk);
    chk("ignore done_none", done, 1'b0);

    // Abort in the 3rd RUN cycle
    go(8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("abort busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort S", S, 8'h00);
    chk("abort Cout", Cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_s = 8'h00; prev_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort no_done", done, 1'b0);
      chk("abort idle", busy, 1'b0);
    end

    go(8'h10, 8'h20, 1'b0);
    follow("t10_20", 8'h30, 1'b0, -1);
    @(negedge clk);

    // Back-to-back: new start presented in the done cycle
    go(8'h10, 8'h20, 1'b0);
    follow("b2b_1", 8'h30, 1'b0, -1);
    go(8'h01, 8'h01, 1'b1);
    follow("b2b_2", 8'h03, 1'b0, -1);
    @(negedge clk);
    chk("b2b done_pulse", done, 1'b0);
    chk("b2b idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
